uart_tx_arbiter: RTL and testbench



---
 rtl/uart_ctrl_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared UART control definitions: arbiter FSM states, data width and default
// requester count.
package uart_ctrl_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins,
// wrapping from NUM_REQ-1 back to 0. Grant is one-hot, idx is its encoding.
module uart_rr_pick
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = ID_W'((32'(ptr) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        gnt[idx] = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional owner lock (req_lock port) is built when UART_ARB_LOCK_EN is defined.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_lock,
`endif
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_done,
    output logic [ID_W-1:0]                grant_id,
    output logic                           busy
);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   start_q, start_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     pick_req;
    logic [NUM_REQ-1:0]     pick_gnt;
    logic [ID_W-1:0]        pick_idx;
    logic [UART_DATA_W-1:0] sel_byte;
    logic [ID_W-1:0]        ptr_next;
    logic                   hold_ptr;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;

    // A locked owner is the only requester IDLE will look at.
    always_comb begin
        pick_req = req_valid;
        if (lock_q) begin
            pick_req = req_valid & (NUM_REQ'(1) << grant_q);
        end
    end

    assign hold_ptr = lock_q;
`else
    assign pick_req = req_valid;
    assign hold_ptr = 1'b0;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (pick_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_byte = req_data[i*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    assign ptr_next = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // Outputs are registered: start/ready are set on the IDLE->LOAD edge so they
    // are high exactly during the LOAD cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        start_d = 1'b0;
        ready_d = '0;
        busy_d  = busy_q;
`ifdef UART_ARB_LOCK_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (|pick_gnt) begin
                    state_d = LOAD;
                    grant_d = pick_idx;
                    data_d  = sel_byte;
                    start_d = 1'b1;
                    ready_d = pick_gnt;
                    busy_d  = 1'b1;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = req_lock[pick_idx];
`endif
                end
            end
            LOAD: begin
                state_d = WAIT_DONE;
                if (!hold_ptr) begin
                    ptr_d = ptr_next;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            ready_q <= '0;
            busy_q  <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            start_q <= start_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign tx_start  = start_q;
    assign tx_data   = data_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a frame-length transmitter
// responder, and a transaction-level arbitration model checked every cycle.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 6;
`ifdef UART_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_lock = '0;
    logic        tx_done = 1'b0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;

    uart_tx_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
`ifdef UART_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    // Arbitration model: one "start" cycle after a grant, then busy until tx_done.
    bit         m_busy = 0, m_load = 0, m_lock = 0, found;
    int         m_owner = 0, m_ptr = 0, c;
    logic [7:0] m_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_load = 0; m_lock = 0; m_owner = 0; m_ptr = 0; m_data = '0;
        end else if (m_load) begin
            m_load = 0;
            if (!m_lock) m_ptr = (m_owner + 1) % N;
        end else if (m_busy) begin
            if (tx_done) m_busy = 0;
        end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && req_valid[c] && (!m_lock || c == m_owner)) begin
                    found   = 1;
                    m_owner = c;
                    m_data  = req_data[c*8 +: 8];
                    m_lock  = LOCK_EN && req_lock[c];
                    m_load  = 1;
                    m_busy  = 1;
                end
            end
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Requester queues
    logic [7:0] rq_data [4][8];
    bit         rq_lock [4][8];
    int         rq_head [4] = '{0, 0, 0, 0};
    int         rq_tail [4] = '{0, 0, 0, 0};

    task automatic push(int r, logic [7:0] d, bit lk);
        rq_data[r][rq_tail[r]] = d;
        rq_lock[r][rq_tail[r]] = lk;
        rq_tail[r]++;
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < N; i++) if (rq_head[i] < rq_tail[i]) p = 1;
        return p;
    endfunction

    // Transmitter responder and transmit log
    logic [7:0] log_byte [16];
    int         log_id   [16];
    int         log_gap  [16];
    int         log_n = 0;
    int         last_done = -100;
    int         tx_cnt = 0;
    bit         inject = 0;

    task automatic service_tx();
        if (!rst_n) begin
            tx_cnt = 0; tx_done = 0; inject = 0;
        end else begin
            tx_done = inject;
            inject  = 0;
            if (tx_start) begin
                if (log_n < 16) begin
                    log_byte[log_n] = tx_data;
                    log_id[log_n]   = int'(grant_id);
                    log_gap[log_n]  = ecnt - last_done;
                    log_n++;
                end
                tx_cnt = FRAME;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_done   = 1;
                    last_done = ecnt;
                end
            end
        end
    endtask

    task automatic service_req();
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && rq_head[i] < rq_tail[i]) rq_head[i]++;
            if (rq_head[i] < rq_tail[i]) begin
                req_valid[i]      = 1'b1;
                req_data[i*8 +: 8] = rq_data[i][rq_head[i]];
                req_lock[i]       = rq_lock[i][rq_head[i]];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_lock[i]       = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        e = {m_load, m_load ? (4'b0001 << m_owner) : 4'b0000, m_data, 2'(m_owner), m_busy};
        chk($sformatf("cycle%0d_outputs", ecnt), {tx_start, req_ready, tx_data, grant_id, busy}, e);
        service_tx();
        service_req();
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((pending() || busy || tx_cnt > 0) && n < budget);
        if (pending() || busy || tx_cnt > 0) chk("wait_idle_timeout", 0, 1);
    endtask

    task automatic wait_start(int budget, output bit ok);
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (tx_start) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int r;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {tx_start, req_ready, tx_data, grant_id, busy}, 16'h0000);
        rst_n = 1'b1;
        tick();

        // tx_done while idle must be ignored
        inject = 1;
        tick();
        tick();
        chk("idle_done_busy", busy, 0);
        chk("idle_done_start", tx_start, 0);
        tick();
        chk("idle_done_nolog", log_n, 0);

        // single request on requester 2
        push(2, 8'hA5, 0);
        tick();
        r = ecnt;
        wait_start(10, ok);
        chk("t1_start_seen", ok, 1);
        chk("t1_latency", ecnt - r, 1);
        chk("t1_ready", req_ready, 4'b0100);
        chk("t1_data", tx_data, 8'hA5);
        chk("t1_grant", grant_id, 2);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (tx_done) ok = 1;
        end
        chk("t1_done_seen", ok, 1);
        chk("t1_busy_at_done", busy, 1);
        chk("t1_data_held", tx_data, 8'hA5);
        tick();
        chk("t1_busy_after_done", busy, 0);
        wait_idle(50);

        // ptr now 3: requests on 1 and 3 -> 3 first, then wrap to 1
        log_n = 0;
        push(1, 8'h31, 0);
        push(3, 8'h33, 0);
        wait_idle(100);
        chk("wrap_count", log_n, 2);
        chk("wrap_first_id", log_id[0], 3);
        chk("wrap_first_byte", log_byte[0], 8'h33);
        chk("wrap_second_id", log_id[1], 1);
        chk("wrap_second_byte", log_byte[1], 8'h31);

        // reset in WAIT_DONE
        log_n = 0;
        push(2, 8'h5A, 0);
        wait_start(10, ok);
        chk("rst_start_seen", ok, 1);
        tick();
        chk("rst_pre_data", tx_data, 8'h5A);
        chk("rst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {tx_start, req_ready, tx_data, grant_id, busy}, 16'h0000);
        tick();
        tick();
        rst_n = 1'b1;

        // ptr restarts at 0: all four valid -> 10, 11, 12, 13 with 2-clock gaps
        log_n = 0;
        for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i), 0);
        wait_idle(200);
        chk("all4_count", log_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("all4_byte%0d", i), log_byte[i], 8'h10 + 8'(i));
            chk($sformatf("all4_id%0d", i), log_id[i], i);
            if (i > 0) chk($sformatf("all4_gap%0d", i), log_gap[i], 2);
        end

`ifdef UART_ARB_LOCK_EN
        push(0, 8'h40, 0);
        wait_idle(50);
        log_n = 0;
        push(1, 8'h01, 1);
        push(1, 8'h02, 1);
        push(1, 8'h03, 0);
        push(0, 8'hE0, 0);
        wait_idle(300);
        chk("lock_count", log_n, 4);
        chk("lock_b0", {log_id[0][7:0], log_byte[0]}, 16'h0101);
        chk("lock_b1", {log_id[1][7:0], log_byte[1]}, 16'h0102);
        chk("lock_b2", {log_id[2][7:0], log_byte[2]}, 16'h0103);
        chk("lock_b3", {log_id[3][7:0], log_byte[3]}, 16'h00E0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
